// File: rtl/bnn_uart_rx.sv
// bnn_uart_rx: oversampled 8N1 UART receiver with byte FIFO.
// Feeds the BNN controller loader over a valid/ready byte stream.
module bnn_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CTS_FREE   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic                 UART_Rx,
  output logic                 UART_CTS,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_B  = BW'(DATA_BITS - 1);
  localparam logic [PW-1:0] DEPTH_W = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] CTS_W   = PW'(CTS_FREE);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [1:0] baud_sync;
  logic [1:0] rx_sync;
  logic       baud_prev;
  logic       tick;
  logic       rx_s;
  logic       rx_prev;
  logic       armed;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        count;
  logic [PW-1:0]        free;
  logic                 full;
  logic                 stop_tick;
  logic                 good;
  logic                 push;
  logic                 pop;

  assign rx_s = rx_sync[1];

  // Synchronise both async inputs and turn baud_clk rises into ticks.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      baud_sync <= 2'b11;
      rx_sync   <= 2'b11;
      baud_prev <= 1'b1;
      tick      <= 1'b0;
    end else begin
      baud_sync <= {baud_sync[0], baud_clk};
      rx_sync   <= {rx_sync[0], UART_Rx};
      baud_prev <= baud_sync[1];
      tick      <= baud_sync[1] & ~baud_prev;
    end
  end

  // Deframing FSM; armed blocks a line that was low out of reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_prev   <= 1'b1;
      armed     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (tick) begin
        rx_prev <= rx_s;
        if (rx_s) armed <= 1'b1;
        unique case (state)
          IDLE: begin
            if (armed && rx_prev && !rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == LAST) begin
              shreg[bit_cnt] <= rx_s;
              tick_cnt       <= '0;
              if (bit_cnt == LAST_B) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          STOP: begin
            if (tick_cnt == LAST) begin
              tick_cnt  <= '0;
              state     <= IDLE;
              frame_err <= ~rx_s;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        endcase
      end
    end
  end

  assign stop_tick = tick && (state == STOP) && (tick_cnt == LAST);
  assign good      = stop_tick & rx_s;
  assign rx_valid  = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = rx_valid & rx_ready;
  assign push      = good & (~full | pop);
  assign count     = wr_ptr - rd_ptr;
  assign free      = DEPTH_W - count;
  assign rx_data   = mem[rd_ptr[AW-1:0]];

  // Show-ahead FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky overflow and registered host flow control.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow <= 1'b0;
      UART_CTS <= 1'b0;
    end else begin
      if (good && full && !pop) overflow <= 1'b1;
      UART_CTS <= (free >= CTS_W);
    end
  end

endmodule

// File: tb/tb_bnn_uart_rx.sv
// tb_bnn_uart_rx: vector table plus scoreboard for bnn_uart_rx.
// Expected bytes are queued when frames are driven.
module tb_bnn_uart_rx;

  localparam time CLK_HALF  = 5ns;
  localparam time BAUD_HALF = 40ns;
  localparam time BIT       = 16 * 2 * BAUD_HALF;

  logic       clk = 1'b0;
  logic       baud_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       UART_Rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       UART_CTS;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_mem [64];
  int         got_n = 0;
  int         rd_i = 0;
  int         fe_cycles = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         fe;
  } vec_t;

  vec_t vecs [5];

  bnn_uart_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_clk (baud_clk),
    .UART_Rx  (UART_Rx),
    .UART_CTS (UART_CTS),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #(CLK_HALF) clk = ~clk;
  always #(BAUD_HALF) baud_clk = ~baud_clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (rx_valid && rx_ready) begin
        got_mem[got_n % 64] = rx_data;
        got_n++;
      end
      if (frame_err) fe_cycles++;
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drain_check(input string tag);
    while (rd_i < got_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: got byte %0h expected none",
                 tag, got_mem[rd_i % 64]);
      end else begin
        check(tag, {24'h0, got_mem[rd_i % 64]}, {24'h0, exp_q.pop_front()});
      end
      rd_i++;
    end
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input int gap);
    UART_Rx = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      UART_Rx = d[i];
      #(BIT);
    end
    UART_Rx = stop;
    #(BIT);
    UART_Rx = 1'b1;
    #(gap * BIT);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 rx_ready = r;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 2, fe: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0, fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 2, fe: 0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, gap: 2, fe: 1};
    vecs[4] = '{data: 8'h55, stop: 1'b1, gap: 2, fe: 0};

    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cts", UART_CTS, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_cts", UART_CTS, 1);
    #(2 * BIT);

    for (int v = 0; v < 5; v++) begin
      fe0 = fe_cycles;
      if (vecs[v].stop) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].gap);
      check($sformatf("vec%0d_ferr", v), fe_cycles - fe0, vecs[v].fe);
      drain_check($sformatf("vec%0d_byte", v));
    end

    fe0 = fe_cycles;
    UART_Rx = 1'b0;
    #(4 * 2 * BAUD_HALF);
    UART_Rx = 1'b1;
    #(2 * BIT);
    check("glitch_ferr", fe_cycles - fe0, 0);
    drain_check("glitch_byte");

    set_ready(1'b0);
    fe0 = fe_cycles;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1, 1);
      if (k == 2) check("full_cts2", UART_CTS, 1);
      if (k == 3) check("full_cts3", UART_CTS, 0);
      if (k == 4) check("full_ovf4", overflow, 0);
    end
    check("full_ovf5", overflow, 1);
    check("full_cts5", UART_CTS, 0);
    check("full_valid", rx_valid, 1);
    check("full_head", rx_data, 8'h01);
    check("full_ferr", fe_cycles - fe0, 0);
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    drain_check("full_drain");
    check("drain_cts", UART_CTS, 1);
    check("drain_ovf", overflow, 1);

    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1);
    check("held_valid", rx_valid, 1);
    UART_Rx = 1'b0;
    #(BIT);
    UART_Rx = 1'b1;
    #(BIT);
    UART_Rx = 1'b1;
    #(BIT);
    UART_Rx = 1'b0;
    #(BIT / 2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #(BIT);
    check("mid_valid", rx_valid, 0);
    check("mid_ovf", overflow, 0);
    UART_Rx = 1'b1;
    #(2 * BIT);
    set_ready(1'b1);
    fe0 = fe_cycles;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 2);
    check("mid_ferr", fe_cycles - fe0, 0);
    drain_check("mid_byte");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_uart_rx.md
# bnn_uart_rx

UART receive front end for the BNN accelerator: oversamples the serial line against the external baud tick, deframes 8N1 characters, and buffers the received bytes in a small FIFO. The FIFO drains through a valid/ready byte stream into the controller's weight/image loader. The block drives UART_CTS so the host pauses before the FIFO can overflow. It sits directly between the pad-level UART_Rx/baud_clk inputs and the bnn_controller byte consumer.

## Interface
- OVERSAMPLE, 16: baud_clk ticks per bit; even, ≥4.
- DATA_BITS, 8: payload bits per frame, LSB first.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- CTS_FREE, 2: UART_CTS is high only while free entries ≥ CTS_FREE.

- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-high reset (driven from the inverted pad reset, so asserted = 1).
- baud_clk  in  1  asynchronous oversample clock, OVERSAMPLE × baud rate, slower than clk/4.
- UART_Rx  in  1  asynchronous serial line; idles high.
- UART_CTS  out  1  1 = host may send.
- rx_data  out  DATA_BITS  FIFO head byte; valid only while rx_valid = 1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head byte when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse when a stop bit samples low.
- overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full; cleared only by reset.

## Operation
- **Input synchronisers.** baud_clk and UART_Rx each pass through a 2-FF synchroniser (sync FFs reset to 1).
  - tick = one-cycle pulse on a synchronised baud_clk rising edge.
  - rx_s = synchronised UART_Rx.
  - rx_prev = rx_s captured at the previous tick (reset 1).
- **FSM states:** IDLE, START, DATA, STOP. tick_cnt is log2(OVERSAMPLE) bits; bit_cnt counts 0..DATA_BITS-1.
- **IDLE:** at a tick with rx_prev=1 and rx_s=0 → START, tick_cnt=0. Falling-edge detection means a held-low break never retriggers.
- **START:** tick_cnt increments per tick.
  - At the tick where tick_cnt = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s = 0 → DATA, tick_cnt=0, bit_cnt=0.
  - rx_s = 1 → IDLE (glitch rejected; no flag).
- **DATA:** at the tick where tick_cnt = OVERSAMPLE-1, sample rx_s into shift register bit bit_cnt (LSB first), reset tick_cnt, and increment bit_cnt. After bit DATA_BITS-1 → STOP.
- **STOP:** at the tick where tick_cnt = OVERSAMPLE-1, sample rx_s, then go to IDLE.
  - rx_s = 1 and FIFO not full → push shift register.
  - rx_s = 1 and FIFO full → drop the byte, set overflow.
  - rx_s = 0 → pulse frame_err, discard the byte.
- **FIFO:** show-ahead. Write/read pointers have log2(FIFO_DEPTH)+1 bits; wrap-around uses the extra MSB for full/empty.
  - Pop occurs when rx_valid & rx_ready.
  - Push and pop in the same cycle are both performed; when the FIFO is full, the pop makes room and the push is accepted.
  - There is no bypass: a push into an empty FIFO is visible the next cycle.
- **Flow control:** UART_CTS = (FIFO_DEPTH − count ≥ CTS_FREE), registered.
- **Reset values:** FSM=IDLE, counters 0, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, overflow=0, UART_CTS=0 during reset and 1 on the first cycle after it.
- **Reset mid-frame:** the partial byte is discarded and the FIFO is emptied. After reset, a line already low does not start a frame until it has been seen high at a tick.

## Timing
- Synchroniser latency is 2 clk; tick is asserted 3 clk after a baud_clk rising edge (2 sync + 1 edge-detect register).
- Push occurs in the cycle of the stop-bit-sample tick. rx_valid and rx_data update 1 clk later.
- frame_err is high in the cycle after the stop-bit-sample tick, for exactly 1 clk.
- UART_CTS updates 1 clk after the count change that causes it.
- Pop takes effect on the clk edge where rx_valid & rx_ready; the next head appears in the same edge's result.
- Minimum frame spacing is 0 idle bits: the stop-bit sample returns to IDLE mid stop bit, so the next start edge is caught.

## Test plan
- **Reset.** Assert rst_n=1 for 3 clk with UART_Rx=1 → rx_valid=0, frame_err=0, overflow=0, UART_CTS=0. After release: UART_CTS=1.
- **Single byte.** Send 0xA5 at OVERSAMPLE=16 with rx_ready=1 → exactly one accepted transfer of 0xA5; frame_err never pulses.
- **Back-to-back bytes.** Send 0x00 then 0xFF with no idle gap → both delivered in order: 0x00, then 0xFF.
- **Glitch and framing error.**
  - Hold UART_Rx low for 4 ticks, then high → no byte and no frame_err.
  - Send 0x3C with stop bit 0 → frame_err pulses once, no byte is pushed, and the next valid 0x55 is received correctly.
- **Full FIFO.** Hold rx_ready=0 and send 0x01..0x05 → UART_CTS drops after the 3rd byte (free=1). Byte 5 is dropped and overflow=1. Then raise rx_ready → 0x01..0x04 drain in order, UART_CTS returns to 1, overflow stays 1.
- **Reset mid-frame.** Pulse rst_n after 3 data bits, then send 0x96 → only 0x96 is received; no partial byte appears.
